// File: rtl/sa_reset_sequencer_if.sv
// rtl/sa_reset_sequencer_if.sv - soft-reset handshake and per-domain reset/idle bundle
interface sa_reset_sequencer_if #(
    parameter int NUM_DOMAINS = 4
) ();
    logic                   soft_req;
    logic                   soft_ack;
    logic [NUM_DOMAINS-1:0] dom_idle;
    logic [NUM_DOMAINS-1:0] dom_reset_;

    modport master (
        output soft_req,
        output dom_idle,
        input  soft_ack,
        input  dom_reset_
    );

    modport slave (
        input  soft_req,
        input  dom_idle,
        output soft_ack,
        output dom_reset_
    );
endinterface

// File: rtl/sa_reset_sequencer.sv
// rtl/sa_reset_sequencer.sv - staggered per-domain reset release with four-phase soft reset
// Optional idle-wait/timeout stage before re-assertion: SA_RESET_SEQ_IDLE_WAIT_EN
module sa_reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int STAGGER_W   = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 inreset_,
    input  logic                 test_mode,
    input  logic                 direct_reset_,
    input  logic [STAGGER_W-1:0] stagger_cfg,
    sa_reset_sequencer_if.slave  seq,
    output logic                 seq_busy,
    output logic                 timeout_err
);
    localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int WAIT_M = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
    localparam int WAIT_W = $clog2(WAIT_M + 1);

    typedef enum logic [1:0] {ST_RELEASE, ST_RUN, ST_DRAIN, ST_ASSERT} state_e;

    state_e                 state_q;
    logic [STAGGER_W-1:0]   cnt_q;
    logic [STAGGER_W-1:0]   stag_q;
    logic [STAGGER_W-1:0]   stag_eff;
    logic [IDX_W-1:0]       idx_q;
    logic [WAIT_W-1:0]      wait_q;
    logic [NUM_DOMAINS-1:0] dom_q;
    logic                   load_q;
    logic                   ack_q;
    logic                   pend_q;
    logic                   busy_q;
`ifdef SA_RESET_SEQ_IDLE_WAIT_EN
    logic                   terr_q;
`else
    logic                   unused_dom_idle;
    assign unused_dom_idle = &seq.dom_idle;
`endif

    // The power-on stagger is taken on the first edge out of reset, which keeps the
    // async reset branch free of non-constant values.
    assign stag_eff = load_q ? stagger_cfg : stag_q;

    always_ff @(posedge clk or negedge inreset_) begin
        if (!inreset_) begin
            state_q <= ST_RELEASE;
            cnt_q   <= '0;
            stag_q  <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            dom_q   <= '0;
            load_q  <= 1'b1;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
`ifdef SA_RESET_SEQ_IDLE_WAIT_EN
            terr_q  <= 1'b0;
`endif
        end else begin
            busy_q <= (state_q != ST_RUN);
            if (ack_q && !seq.soft_req) begin
                ack_q <= 1'b0;
            end
            if (load_q) begin
                stag_q <= stagger_cfg;
                load_q <= 1'b0;
            end
            case (state_q)
                ST_RELEASE: begin
                    if (cnt_q == stag_eff) begin
                        dom_q[idx_q] <= 1'b1;
                        cnt_q        <= '0;
                        if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                            state_q <= ST_RUN;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + STAGGER_W'(1);
                    end
                end
                ST_RUN: begin
                    // A completed soft sequence acknowledges before any new request is looked at.
                    if (pend_q) begin
                        ack_q  <= 1'b1;
                        pend_q <= 1'b0;
                    end else if (seq.soft_req && !ack_q) begin
                        pend_q <= 1'b1;
                        wait_q <= '0;
`ifdef SA_RESET_SEQ_IDLE_WAIT_EN
                        terr_q  <= 1'b0;
                        state_q <= ST_DRAIN;
`else
                        dom_q   <= '0;
                        state_q <= ST_ASSERT;
`endif
                    end
                end
`ifdef SA_RESET_SEQ_IDLE_WAIT_EN
                ST_DRAIN: begin
                    if (&seq.dom_idle) begin
                        dom_q   <= '0;
                        wait_q  <= '0;
                        state_q <= ST_ASSERT;
                    end else if (wait_q == WAIT_W'(TIMEOUT)) begin
                        terr_q  <= 1'b1;
                        dom_q   <= '0;
                        wait_q  <= '0;
                        state_q <= ST_ASSERT;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
`endif
                ST_ASSERT: begin
                    if (wait_q == WAIT_W'(HOLD_CYCLES - 1)) begin
                        stag_q  <= stagger_cfg;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        wait_q  <= '0;
                        state_q <= ST_RELEASE;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                default: state_q <= ST_RELEASE;
            endcase
        end
    end

    assign seq.dom_reset_ = test_mode ? {NUM_DOMAINS{direct_reset_}} : dom_q;
    assign seq.soft_ack   = ack_q;
    assign seq_busy       = busy_q;
`ifdef SA_RESET_SEQ_IDLE_WAIT_EN
    assign timeout_err    = terr_q;
`else
    assign timeout_err    = 1'b0;
`endif
endmodule

// File: tb/tb_sa_reset_sequencer.sv
// tb/tb_sa_reset_sequencer.sv - vector table plus directed soft-reset sequences for sa_reset_sequencer
module tb_sa_reset_sequencer;
    localparam int N       = 4;
    localparam int HOLD    = 4;
    localparam int TIMEOUT = 255;
`ifdef SA_RESET_SEQ_IDLE_WAIT_EN
    localparam int       D        = 1;
    localparam logic     EXP_TERR = 1'b1;
`else
    localparam int       D        = 0;
    localparam logic     EXP_TERR = 1'b0;
`endif

    logic           clk;
    logic           inreset_;
    logic           test_mode;
    logic           direct_reset_;
    logic [7:0]     stagger_cfg;
    logic           seq_busy;
    logic           timeout_err;

    sa_reset_sequencer_if #(.NUM_DOMAINS(N)) seq ();

    sa_reset_sequencer #(
        .NUM_DOMAINS(N),
        .STAGGER_W  (8),
        .HOLD_CYCLES(HOLD),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .inreset_     (inreset_),
        .test_mode    (test_mode),
        .direct_reset_(direct_reset_),
        .stagger_cfg  (stagger_cfg),
        .seq          (seq),
        .seq_busy     (seq_busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        int         stag;
        int         edge_no;
        logic [3:0] dom;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   tests;
    int   fails;
    int   edge_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset(input int stag);
        @(negedge clk);
        inreset_      = 1'b0;
        seq.soft_req  = 1'b0;
        stagger_cfg   = 8'(stag);
        repeat (2) @(negedge clk);
        inreset_ = 1'b1;
        edge_n   = 0;
    endtask

    task automatic wait_ack(input string name);
        int k;
        k = 0;
        while (seq.soft_ack !== 1'b1 && k < 400) begin
            step();
            k++;
        end
        chk(name, seq.soft_ack, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cur;
        tests         = 0;
        fails         = 0;
        edge_n        = 0;
        inreset_      = 1'b0;
        test_mode     = 1'b0;
        direct_reset_ = 1'b0;
        stagger_cfg   = 8'd0;
        seq.soft_req  = 1'b0;
        seq.dom_idle  = 4'hF;

        // power-on release, stagger 3 then stagger 0; stagger_cfg jumps to 9 after edge 1
        vecs.push_back(vec_t'{0, 3,  0, 4'h0, 1'b1});
        vecs.push_back(vec_t'{0, 3,  3, 4'h0, 1'b1});
        vecs.push_back(vec_t'{0, 3,  4, 4'h1, 1'b1});
        vecs.push_back(vec_t'{0, 3,  7, 4'h1, 1'b1});
        vecs.push_back(vec_t'{0, 3,  8, 4'h3, 1'b1});
        vecs.push_back(vec_t'{0, 3, 12, 4'h7, 1'b1});
        vecs.push_back(vec_t'{0, 3, 15, 4'h7, 1'b1});
        vecs.push_back(vec_t'{0, 3, 16, 4'hF, 1'b1});
        vecs.push_back(vec_t'{0, 3, 17, 4'hF, 1'b0});
        vecs.push_back(vec_t'{1, 0,  0, 4'h0, 1'b1});
        vecs.push_back(vec_t'{1, 0,  1, 4'h1, 1'b1});
        vecs.push_back(vec_t'{1, 0,  2, 4'h3, 1'b1});
        vecs.push_back(vec_t'{1, 0,  3, 4'h7, 1'b1});
        vecs.push_back(vec_t'{1, 0,  4, 4'hF, 1'b1});
        vecs.push_back(vec_t'{1, 0,  5, 4'hF, 1'b0});
        vecs.push_back(vec_t'{1, 0, 12, 4'hF, 1'b0});

        cur = -1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].id != cur) begin
                cur = vecs[i].id;
                do_reset(vecs[i].stag);
            end
            while (edge_n < vecs[i].edge_no) begin
                step();
                if (edge_n == 1) stagger_cfg = 8'd9;
            end
            chk($sformatf("vec%0d_dom", i), seq.dom_reset_, vecs[i].dom);
            chk($sformatf("vec%0d_busy", i), seq_busy, vecs[i].busy);
            chk($sformatf("vec%0d_ack", i), seq.soft_ack, 1'b0);
            chk($sformatf("vec%0d_terr", i), timeout_err, 1'b0);
        end

        // soft reset with all domains idle, re-release at stagger 1
        seq.dom_idle = 4'hF;
        stagger_cfg  = 8'd1;
        seq.soft_req = 1'b1;
        step();
        chk("soft_busy_accept", seq_busy, 1'b0);
        chk("soft_dom_accept", seq.dom_reset_, (D == 1) ? 4'hF : 4'h0);
        step();
        chk("soft_busy_next", seq_busy, 1'b1);
        chk("soft_dom_assert", seq.dom_reset_, 4'h0);
        steps(D + 3);
        chk("soft_dom_hold_end", seq.dom_reset_, 4'h0);
        step();
        chk("soft_dom_rel_wait", seq.dom_reset_, 4'h0);
        step();
        chk("soft_dom_rel0", seq.dom_reset_, 4'h1);
        steps(6);
        chk("soft_dom_rel3", seq.dom_reset_, 4'hF);
        chk("soft_busy_rel3", seq_busy, 1'b1);
        chk("soft_ack_rel3", seq.soft_ack, 1'b0);
        step();
        chk("soft_busy_run", seq_busy, 1'b0);
        chk("soft_ack_rise", seq.soft_ack, 1'b1);
        steps(3);
        chk("soft_ack_held", seq.soft_ack, 1'b1);
        chk("soft_no_reaccept", seq_busy, 1'b0);
        seq.soft_req = 1'b0;
        step();
        chk("soft_ack_fall", seq.soft_ack, 1'b0);
        step();
        chk("soft_busy_after", seq_busy, 1'b0);

        // DRAIN with a domain that never goes idle
        seq.dom_idle = 4'h7;
        seq.soft_req = 1'b1;
        step();
`ifdef SA_RESET_SEQ_IDLE_WAIT_EN
        steps(TIMEOUT);
        chk("to_dom_before", seq.dom_reset_, 4'hF);
        chk("to_terr_before", timeout_err, 1'b0);
        chk("to_busy_drain", seq_busy, 1'b1);
        step();
        chk("to_dom_assert", seq.dom_reset_, 4'h0);
        chk("to_terr_set", timeout_err, 1'b1);
`else
        chk("to_dom_assert", seq.dom_reset_, 4'h0);
        step();
        chk("to_terr_tied", timeout_err, 1'b0);
`endif
        wait_ack("to_ack_wait");
        chk("to_terr_sticky", timeout_err, EXP_TERR);
        seq.soft_req = 1'b0;
        step();
        chk("to_ack_fall", seq.soft_ack, 1'b0);
        chk("to_terr_still", timeout_err, EXP_TERR);
        seq.dom_idle = 4'hF;
        seq.soft_req = 1'b1;
        step();
        chk("to_terr_clear", timeout_err, 1'b0);
        wait_ack("to_ack_wait2");
        seq.soft_req = 1'b0;
        step();
        chk("to_ack_fall2", seq.soft_ack, 1'b0);

        // test-mode bypass is combinational and leaves the FSM outputs alone
        test_mode     = 1'b1;
        direct_reset_ = 1'b0;
        #1;
        chk("tm_dom_low", seq.dom_reset_, 4'h0);
        chk("tm_busy", seq_busy, 1'b0);
        chk("tm_ack", seq.soft_ack, 1'b0);
        direct_reset_ = 1'b1;
        #1;
        chk("tm_dom_high", seq.dom_reset_, 4'hF);
        direct_reset_ = 1'b0;
        #1;
        chk("tm_dom_low2", seq.dom_reset_, 4'h0);
        step();
        chk("tm_dom_edge", seq.dom_reset_, 4'h0);
        chk("tm_busy_edge", seq_busy, 1'b0);
        test_mode = 1'b0;
        #1;
        chk("tm_exit_dom", seq.dom_reset_, 4'hF);

        // async reset in the middle of a soft sequence drops the handshake
        seq.soft_req = 1'b1;
        step();
        steps(D + 1);
        chk("rst_in_assert_dom", seq.dom_reset_, 4'h0);
        inreset_ = 1'b0;
        #1;
        chk("rst_dom", seq.dom_reset_, 4'h0);
        chk("rst_busy", seq_busy, 1'b1);
        chk("rst_ack", seq.soft_ack, 1'b0);
        chk("rst_terr", timeout_err, 1'b0);
        seq.soft_req = 1'b0;
        stagger_cfg  = 8'd2;
        repeat (2) @(negedge clk);
        chk("rst_hold_dom", seq.dom_reset_, 4'h0);
        inreset_ = 1'b1;
        edge_n   = 0;
        steps(2);
        chk("rst_rel_e2", seq.dom_reset_, 4'h0);
        step();
        chk("rst_rel_e3", seq.dom_reset_, 4'h1);
        steps(9);
        chk("rst_rel_e12", seq.dom_reset_, 4'hF);
        chk("rst_busy_e12", seq_busy, 1'b1);
        step();
        chk("rst_busy_e13", seq_busy, 1'b0);
        chk("rst_ack_e13", seq.soft_ack, 1'b0);
        steps(2);
        chk("rst_ack_e15", seq.soft_ack, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
